keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 100000; clk cycles each column is held active before advancing (1 ms at 100 MHz).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000; consecutive stable clk cycles required to accept a press or a release (10 ms at 100 MHz).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 row_n  input  4  keypad row lines, active-low, asynchronous to clk.
REQ-006 col_n  output  4  keypad column drives, active-low, exactly one low at a time.
REQ-007 key_code  output  4  hex value of the last accepted key; feeds the downstream 4-bit load register DIN.
REQ-008 key_ld  output  1  one-cycle pulse when key_code is updated; feeds the downstream register LD.

Function
REQ-009 row_n shall pass through a 2-flop synchronizer before any use; synchronizer latency is 2 cycles.
REQ-010 Key map (row r, col c, index 0-3): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D.
REQ-011 FSM states: SCAN, DEBOUNCE, EMIT, HELD, RELEASE.
REQ-012 SCAN: col index advances 0->1->2->3->0 every SCAN_CYCLES cycles; col_n = ~(4'b0001 << index).
REQ-013 SCAN -> DEBOUNCE when exactly one synced row bit is low; latch row index and hold column index fixed.
REQ-014 Zero or more than one synced row low in SCAN: no transition (multi-key treated as no press).
REQ-015 DEBOUNCE: counter increments while synced row_n equals latched pattern; any mismatch returns to SCAN with counter cleared.
REQ-016 DEBOUNCE -> EMIT when counter reaches DEBOUNCE_CYCLES-1.
REQ-017 EMIT (one cycle): key_code <= map(row, col), key_ld = 1; next state HELD.
REQ-018 HELD: column held; -> RELEASE when synced row_n == 4'hF.
REQ-019 RELEASE: counter increments while row_n == 4'hF; any low row returns to HELD with counter cleared; -> SCAN after DEBOUNCE_CYCLES stable cycles.
REQ-020 A held key shall produce exactly one key_ld pulse regardless of hold duration (no auto-repeat).
REQ-021 key_ld is registered and high only in the cycle following entry to EMIT; never high two consecutive cycles.
REQ-022 key_code holds its value between pulses; changes only coincident with key_ld.
REQ-023 Counters sized $clog2 of their parameter, saturate never exceeded; scan counter wraps to 0 on column advance.
REQ-024 Column index wraps 3 -> 0 without a skipped or repeated column.

Reset
REQ-025 rst_n low asynchronously forces: state SCAN, column index 0, col_n = 4'b1110, counters 0, key_code 4'h0, key_ld 0, synchronizer flops 4'hF.
REQ-026 Reset asserted mid-DEBOUNCE, EMIT, or HELD aborts the press with no key_ld pulse; after release, scanning restarts from column 0.

Structure
REQ-027 Shared package keypad_pkg holds the FSM state enum and the 16-entry key map constant.
REQ-028 One sub-module, kp_sync, implements the 2-flop 4-bit row synchronizer with async active-low reset to 4'hF.
REQ-029 Implementation target 120-400 lines RTL; single clock domain, no latches, no gated clocks.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-030 Reset release, no keys -> col_n cycles 1110,1101,1011,0111,1110 each held 4 cycles; key_ld never asserts.
REQ-031 row_n=4'b1011 while col_n=4'b1101, held 20 cycles -> exactly one key_ld pulse, key_code=4'h8.
REQ-032 Key "D" (row3, col3) pressed with 3-cycle bounce then stable 50 cycles -> single key_ld, key_code=4'hD; release bounce yields no extra pulse.
REQ-033 row_n=4'b1001 (two rows low) for 40 cycles -> no key_ld; scanning continues.
REQ-034 rst_n pulsed low 2 cycles during DEBOUNCE of key "5" -> no key_ld, key_code=4'h0, col_n=4'b1110 immediately.
REQ-035 Press "1", release, press "0" -> two key_ld pulses, key_code 4'h1 then 4'h0, each separated by full release debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared definitions for the 4x4 keypad scanner: FSM state
//            encoding, matrix dimensions and the row/column -> hex key map.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int c_num_rows = 4;
  localparam int c_num_cols = 4;

  typedef enum logic [2:0] {
    ST_SCAN     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_EMIT     = 3'd2,
    ST_HELD     = 3'd3,
    ST_RELEASE  = 3'd4
  } kp_state_e;

  // 16 nibbles indexed by {row, col}; nibble 0 (LSB) is row 0 / col 0.
  //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: 0 F E D
  localparam logic [63:0] c_key_map = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] row,
                                            input logic [1:0] col);
    return c_key_map[{row, col, 2'b00} +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_sync.sv
`default_nettype none
// ============================================================================
// Module   : kp_sync
// Purpose  : Two-flop synchronizer for the asynchronous, active-low keypad
//            rows. Resets to all-ones so an idle keypad is seen during reset.
// Ports    : clk         - system clock
//            rst_n       - asynchronous active-low reset
//            row_n_async - raw row lines from the keypad
//            row_n_sync  - rows after two flops (2-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module kp_sync
  import keypad_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [c_num_rows-1:0] row_n_async,
  output logic [c_num_rows-1:0] row_n_sync
);

  logic [c_num_rows-1:0] meta_q, meta_d;
  logic [c_num_rows-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = row_n_async;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign row_n_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Scans a 4x4 matrix keypad one column at a time, debounces a
//            single-key press and release, and emits the hex code of each
//            accepted key exactly once per press.
// Ports    : clk      - system clock (rising edge)
//            rst_n    - asynchronous active-low reset
//            row_n    - keypad rows, active-low, asynchronous
//            col_n    - keypad column drives, exactly one low
//            key_code - hex value of the last accepted key
//            key_ld   - one-cycle load strobe, coincident with key_code update
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_ld
);

  localparam int c_scan_w = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int c_deb_w  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_CYCLES - 1);
  localparam logic [c_deb_w-1:0]  c_deb_last  = c_deb_w'(DEBOUNCE_CYCLES - 1);

  kp_state_e           state_q, state_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [c_scan_w-1:0] scan_cnt_q, scan_cnt_d;
  logic [c_deb_w-1:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_ld_q, key_ld_d;

  logic [3:0] row_sync;
  logic [3:0] row_low;
  logic       one_low;
  logic [1:0] row_enc;
  logic [3:0] latched_pat;

  kp_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_n_async (row_n),
    .row_n_sync  (row_sync)
  );

  // Exactly one row low: non-zero and a power of two. Any multi-key pattern
  // is treated as no press.
  assign row_low     = ~row_sync;
  assign one_low     = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
  assign latched_pat = ~(4'b0001 << row_idx_q);

  always_comb begin
    row_enc = 2'd0;
    case (row_low)
      4'b0010: row_enc = 2'd1;
      4'b0100: row_enc = 2'd2;
      4'b1000: row_enc = 2'd3;
      default: row_enc = 2'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    row_idx_d  = row_idx_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    key_code_d = key_code_q;
    key_ld_d   = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (one_low) begin
          // Freeze the column on the one that produced the press; the dwell
          // timer restarts if the press turns out to be a bounce.
          state_d    = ST_DEBOUNCE;
          row_idx_d  = row_enc;
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
        end else if (scan_cnt_q == c_scan_last) begin
          scan_cnt_d = '0;
          col_idx_d  = col_idx_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (row_sync == latched_pat) begin
          if (deb_cnt_q == c_deb_last) begin
            state_d   = ST_EMIT;
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else begin
          state_d   = ST_SCAN;
          deb_cnt_d = '0;
        end
      end

      ST_EMIT: begin
        // Code and strobe register together so they change in the same cycle.
        key_code_d = key_lookup(row_idx_q, col_idx_q);
        key_ld_d   = 1'b1;
        state_d    = ST_HELD;
      end

      ST_HELD: begin
        if (row_sync == 4'hF) begin
          state_d   = ST_RELEASE;
          deb_cnt_d = '0;
        end
      end

      ST_RELEASE: begin
        if (row_sync == 4'hF) begin
          if (deb_cnt_q == c_deb_last) begin
            state_d   = ST_SCAN;
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else begin
          state_d   = ST_HELD;
          deb_cnt_d = '0;
        end
      end

      default: begin
        state_d    = ST_SCAN;
        scan_cnt_d = '0;
        deb_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SCAN;
      col_idx_q  <= 2'd0;
      row_idx_q  <= 2'd0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      key_code_q <= 4'h0;
      key_ld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      key_code_q <= key_code_d;
      key_ld_q   <= key_ld_d;
    end
  end

  assign col_n    = ~(4'b0001 << col_idx_q);
  assign key_code = key_code_q;
  assign key_ld   = key_ld_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Self-checking bench for keypad_scanner. A behavioural keypad
//            matrix drives the rows from the scanned columns; expected key
//            codes are queued at stimulus time and consumed by a monitor on
//            every key_ld strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN = 4;
  localparam int DEB  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_ld;

  logic [15:0] pressed;    // bit r*4+c = key at row r, column c held down
  logic        force_en;
  logic [3:0]  force_row;

  int unsigned ref_map [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11},
                                  '{7, 8, 9, 12}, '{0, 15, 14, 13}};

  logic [3:0] sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] prev_code = 4'h0;
  logic       prev_ld   = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_CYCLES     (SCAN),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_ld   (key_ld)
  );

  // Passive switch matrix: a row reads low when a pressed key connects it to
  // a column currently driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    if (force_en) row_n = force_row;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] ref_key(input int r, input int c);
    return 4'(ref_map[r][c]);
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_code = key_code;
      prev_ld   = 1'b0;
    end else begin
      chk("col_one_low", $countones(~col_n), 1);
      if (key_ld) begin
        chk("ld_not_back_to_back", {31'd0, prev_ld}, 0);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_key_ld: key_code %0h with no key expected at %0t",
                   key_code, $time);
        end else begin
          logic [3:0] e;
          e = sb.pop_front();
          chk("key_code", key_code, e);
        end
      end else begin
        chk("code_stable_without_ld", key_code, prev_code);
      end
      prev_code = key_code;
      prev_ld   = key_ld;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_press(input logic [15:0] mask, input int bounce, input int stable,
                           input int rel_bounce, input int idle);
    repeat (bounce) begin
      pressed = mask;  tick($urandom_range(1, 3));
      pressed = '0;    tick($urandom_range(1, 2));
    end
    pressed = mask;
    tick(stable);
    repeat (rel_bounce) begin
      pressed = '0;    tick($urandom_range(1, 3));
      pressed = mask;  tick($urandom_range(1, 2));
    end
    pressed = '0;
    tick(idle);
  endtask

  // Wait for the scanner to newly drive column pattern v (bounded).
  task automatic wait_col_enter(input logic [3:0] v);
    int n = 0;
    while (col_n == v && n < 64) begin @(negedge clk); n++; end
    while (col_n != v && n < 128) begin @(negedge clk); n++; end
    chk("wait_col_enter", col_n, v);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seen;
    logic [3:0] e;
    pressed   = '0;
    force_en  = 1'b0;
    force_row = 4'hF;
    rst_n     = 1'b0;
    tick(3);
    #1;
    chk("reset_col_n", col_n, 4'b1110);
    chk("reset_key_code", key_code, 4'h0);
    chk("reset_key_ld", key_ld, 1'b0);

    // Idle scanning: each column held SCAN cycles, wrapping 3 -> 0.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5 * SCAN; k++) begin
      e = ~(4'd1 << ((k / SCAN) % 4));
      chk("idle_col_seq", col_n, e);
      @(negedge clk);
    end

    // Key "8" (row 2, col 1) pressed as column 1 becomes active.
    wait_col_enter(4'b1101);
    sb.push_back(ref_key(2, 1));
    pressed = 16'd1 << (2*4 + 1);
    tick(20);
    pressed = '0;
    tick(40);

    // Key "D" with press and release bounce.
    sb.push_back(ref_key(3, 3));
    key_press(16'd1 << 15, 3, 50, 3, 40);

    // Two rows low regardless of column: ignored, scanning continues.
    force_en  = 1'b1;
    force_row = 4'b1001;
    seen = 4'h0;
    for (int k = 0; k < 40; k++) begin
      seen = seen | ~col_n;
      tick(1);
    end
    force_en = 1'b0;
    chk("multi_key_scan_continues", seen, 4'hF);
    tick(20);

    // Reset during debounce of key "5" aborts the press.
    wait_col_enter(4'b1101);
    pressed = 16'd1 << (1*4 + 1);
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("abort_col_n", col_n, 4'b1110);
    chk("abort_key_code", key_code, 4'h0);
    chk("abort_key_ld", key_ld, 1'b0);
    tick(2);
    pressed = '0;
    rst_n   = 1'b1;
    tick(30);
    chk("abort_code_after", key_code, 4'h0);

    // "1" then "0", each fully released.
    sb.push_back(ref_key(0, 0));
    key_press(16'd1 << 0, 0, 60, 0, 40);
    sb.push_back(ref_key(3, 0));
    key_press(16'd1 << 12, 0, 60, 0, 40);

    // Randomized presses: single keys, or two keys sharing a column.
    for (int i = 0; i < 14; i++) begin
      int r, c, r2;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        r2 = (r + $urandom_range(1, 3)) % 4;
        key_press((16'd1 << (r*4 + c)) | (16'd1 << (r2*4 + c)),
                  $urandom_range(0, 3), 60, $urandom_range(0, 3), 40);
      end else begin
        sb.push_back(ref_key(r, c));
        key_press(16'd1 << (r*4 + c), $urandom_range(0, 3), 60,
                  $urandom_range(0, 3), 40);
      end
    end

    tick(50);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
